// File: rtl/op_seq_pkg.sv
// rtl/op_seq_pkg.sv - shared types and constants for the opcode sequencer
package op_seq_pkg;

    localparam int OP_W_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [OP_W_DEF-1:0] OP_000 = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_001 = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_010 = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_011 = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_100 = 3'd4;
    localparam logic [OP_W_DEF-1:0] OP_101 = 3'd5;
    localparam logic [OP_W_DEF-1:0] OP_110 = 3'd6;
    localparam logic [OP_W_DEF-1:0] OP_111 = 3'd7;

endpackage

// File: rtl/op_sequencer_timer.sv
// rtl/op_sequencer_timer.sv - load/enable/expire down-counter shared by hold and timeout
// Ports: clk, rst (async active-low), load/load_val (preset), en (decrement),
//        expired (count has reached zero).
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - sweeps opcodes first..last into a datapath with ack/hold/timeout
// Ports: clk, rst (async active-low); start/first_op/last_op launch a sweep;
//        ack accepts the offered opcode; abort cancels. Outputs opcode/op_valid
//        to the datapath, busy, done (pulse), err (sticky timeout), issued count.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] first_op,
    input  logic [OP_W-1:0] last_op,
    input  logic            ack,
    input  logic            abort,
    output logic [OP_W-1:0] opcode,
    output logic            op_valid,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [OP_W:0]   issued
);

    // Timer presets are "cycles minus one": the state is left on the cycle
    // the counter reads zero.
    localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LOAD = 8'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [OP_W:0] ISSUED_MAX = {1'b1, {OP_W{1'b0}}};

    state_t state, state_n;
    logic [OP_W-1:0] cur, cur_n, last_q, last_n, opcode_n;
    logic            op_valid_n, done_n, err_n;
    logic [OP_W:0]   issued_n;
    logic            t_load, t_en, t_exp;
    logic [7:0]      t_val;
    logic [OP_W-1:0] cur_inc;

    assign cur_inc = cur + 1'b1;

    seq_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .en       (t_en),
        .load_val (t_val),
        .expired  (t_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            last_q   <= '0;
            opcode   <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            issued   <= '0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            last_q   <= last_n;
            opcode   <= opcode_n;
            op_valid <= op_valid_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
            err      <= err_n;
            issued   <= issued_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        last_n     = last_q;
        opcode_n   = opcode;
        op_valid_n = op_valid;
        done_n     = 1'b0;
        err_n      = err;
        issued_n   = issued;
        t_load     = 1'b0;
        t_en       = 1'b0;
        t_val      = '0;

        if (abort) begin
            state_n    = S_IDLE;
            op_valid_n = 1'b0;
            opcode_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    opcode_n   = '0;
                    op_valid_n = 1'b0;
                    if (start) begin
                        cur_n      = first_op;
                        last_n     = last_op;
                        err_n      = 1'b0;
                        issued_n   = '0;
                        state_n    = S_ISSUE;
                        opcode_n   = first_op;
                        op_valid_n = 1'b1;
                        t_load     = 1'b1;
                        t_val      = TO_LOAD;
                    end
                end
                S_ISSUE: begin
                    if (ack && op_valid) begin
                        if (issued != ISSUED_MAX) begin
                            issued_n = issued + 1'b1;
                        end
                        op_valid_n = 1'b0;
                        if (HOLD != 0) begin
                            state_n = S_HOLD;
                            t_load  = 1'b1;
                            t_val   = HOLD_LOAD;
                        end else if (cur == last_q) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                        end else begin
                            // No hold stage: offer the next opcode straight away.
                            cur_n      = cur_inc;
                            opcode_n   = cur_inc;
                            op_valid_n = 1'b1;
                            t_load     = 1'b1;
                            t_val      = TO_LOAD;
                        end
                    end else if (t_exp) begin
                        // Ack checked first so an ack on the final wait cycle wins.
                        err_n      = 1'b1;
                        state_n    = S_IDLE;
                        op_valid_n = 1'b0;
                        opcode_n   = '0;
                    end else begin
                        t_en = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (t_exp) begin
                        if (cur == last_q) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                        end else begin
                            cur_n      = cur_inc;
                            opcode_n   = cur_inc;
                            op_valid_n = 1'b1;
                            state_n    = S_ISSUE;
                            t_load     = 1'b1;
                            t_val      = TO_LOAD;
                        end
                    end else begin
                        t_en = 1'b1;
                    end
                end
                S_DONE: begin
                    state_n    = S_IDLE;
                    opcode_n   = '0;
                    op_valid_n = 1'b0;
                end
                default: begin
                    state_n    = S_IDLE;
                    opcode_n   = '0;
                    op_valid_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - scoreboard bench for op_sequencer
module tb_op_sequencer;
    import op_seq_pkg::*;

    localparam int OP_W    = 3;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            ack = 1'b0;
    logic            abort = 1'b0;
    logic [OP_W-1:0] first_op = '0;
    logic [OP_W-1:0] last_op = '0;
    logic [OP_W-1:0] opcode;
    logic            op_valid, busy, done, err;
    logic [OP_W:0]   issued;

    int errors = 0;
    int checks = 0;
    int exp_op[$];
    int exp_done[$];
    int done_cnt = 0;

    op_sequencer #(.OP_W(OP_W), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .first_op (first_op),
        .last_op  (last_op),
        .ack      (ack),
        .abort    (abort),
        .opcode   (opcode),
        .op_valid (op_valid),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .issued   (issued)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted opcode and every done pulse against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (op_valid && ack) begin
                chk("ack_expected", exp_op.size() != 0, 1);
                if (exp_op.size() != 0) chk("opcode_seq", opcode, exp_op.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) chk("done_issued", issued, exp_done.pop_front());
            end
        end
    end

    task automatic run_sweep(input logic [2:0] f, input logic [2:0] l, input int ack_delay,
                             input int abort_at, input bit noise);
        int n;
        int base;
        int t;
        int e;
        n = ((int'(l) - int'(f)) & 7) + 1;
        base = done_cnt;
        for (int k = 0; k < n; k++)
            if (abort_at < 0 || k <= abort_at) exp_op.push_back((int'(f) + k) & 7);
        if (abort_at < 0) exp_done.push_back(n);
        @(negedge clk);
        first_op = f; last_op = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", err, 0);
        chk("issued_cleared", issued, 0);
        chk("busy_on_start", busy, 1);
        for (int k = 0; k < n; k++) begin
            e = (int'(f) + k) & 7;
            t = 0;
            while (!op_valid && t < 40) begin @(negedge clk); t++; end
            chk("op_valid_wait", op_valid, 1);
            repeat (ack_delay) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("op_valid_after_ack", op_valid, 0);
            chk("issued_count", issued, k + 1);
            for (int h = 0; h < HOLD; h++) begin
                if (h > 0) @(negedge clk);
                chk("hold_opcode", opcode, e);
                chk("hold_valid_low", op_valid, 0);
                if (k == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    chk("abort_valid", op_valid, 0);
                    chk("abort_issued", issued, k + 1);
                    chk("abort_err", err, 0);
                    @(negedge clk);
                    chk("abort_no_done", done_cnt - base, 0);
                    return;
                end
                if (noise && h == 0) begin
                    start = 1'b1; first_op = 3'd7; ack = 1'b1;
                end
                if (noise && h == 1) begin
                    start = 1'b0; ack = 1'b0;
                end
            end
            start = 1'b0; ack = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_opcode", opcode, OP_000);
        chk("final_issued", issued, n);
        chk("final_err", err, 0);
        chk("done_count", done_cnt - base, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_opcode", opcode, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_issued", issued, 0);
        rst = 1'b1;
        @(negedge clk);

        // Full ascending sweep, then a wrapping sweep with start/ack noise in HOLD.
        run_sweep(3'd0, 3'd7, 1, -1, 1'b0);
        run_sweep(3'd6, 3'd1, 1, -1, 1'b1);

        // Timeout: never ack opcode 3.
        @(negedge clk);
        first_op = OP_011; last_op = OP_100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (op_valid && t < 40) begin t++; @(negedge clk); end
        chk("timeout_cycles", t, TIMEOUT);
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_opcode", opcode, 0);
        chk("timeout_issued", issued, 0);
        chk("timeout_no_done", done, 0);
        run_sweep(3'd0, 3'd0, 1, -1, 1'b0);

        // Ack arriving on the final wait cycle is accepted.
        run_sweep(3'd2, 3'd2, TIMEOUT - 1, -1, 1'b0);

        // Abort in the HOLD of opcode 2.
        run_sweep(3'd0, 3'd7, 1, 2, 1'b0);

        // Ack while idle has no effect.
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_issued", issued, 3);
        chk("idle_ack_busy", busy, 0);

        // Reset between edges while opcode 6 is offered.
        exp_op.push_back(5);
        first_op = OP_101; last_op = OP_111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("pre_rst_opcode", opcode, 6);
        chk("pre_rst_valid", op_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_opcode", opcode, 0);
        chk("async_rst_valid", op_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_issued", issued, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", op_valid, 0);

        chk("op_queue_empty", exp_op.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 3: opcode width.
REQ-002 SHALL have parameter HOLD, default 2: cycles the opcode stays stable after ack, 0..15.
REQ-003 SHALL have parameter TIMEOUT, default 15: max cycles waiting for ack, 1..255.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin sweep; sampled only in IDLE.
REQ-007 SHALL have port first_op, input, OP_W: first opcode; latched on accepted start.
REQ-008 SHALL have port last_op, input, OP_W: final opcode; latched on accepted start.
REQ-009 SHALL have port ack, input, 1: datapath accepted or completed the current opcode.
REQ-010 SHALL have port abort, input, 1: cancel sweep.
REQ-011 SHALL have port opcode, output, OP_W: opcode driven to the ALU/register-bank datapath.
REQ-012 SHALL have port op_valid, output, 1: opcode is offered and awaits ack.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a sweep completes normally.
REQ-015 SHALL have port err, output, 1: sticky timeout flag.
REQ-016 SHALL have port issued, output, OP_W+1: number of opcodes acked in the current or last sweep.

Function
REQ-017 SHALL implement states IDLE, ISSUE, HOLD and DONE; all outputs SHALL be registered.
REQ-018 In IDLE with start=1, SHALL latch first_op and last_op into cur/last, clear err and issued, and enter ISSUE next cycle.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 In ISSUE, SHALL drive op_valid=1 and opcode=cur, keeping opcode stable until ack.
REQ-021 ack with op_valid=1 SHALL increment issued, deassert op_valid next cycle and enter HOLD; ack with op_valid=0 SHALL be ignored.
REQ-022 In HOLD, opcode SHALL stay at cur for HOLD cycles; HOLD=0 SHALL bypass HOLD with no extra cycle.
REQ-023 On leaving HOLD with cur==last, SHALL enter DONE; otherwise cur SHALL become cur+1 mod 2^OP_W and the FSM SHALL return to ISSUE.
REQ-024 last<first SHALL wrap 7->0; sweep length SHALL be ((last-first) mod 2^OP_W)+1, so first==last issues exactly one opcode.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE with opcode=0.
REQ-026 A wait counter SHALL clear on ISSUE entry and count cycles without ack; at TIMEOUT it SHALL set err=1 and go to IDLE with no done pulse.
REQ-027 ack in the same cycle the counter reaches TIMEOUT SHALL win: no err, normal HOLD.
REQ-028 abort SHALL have highest priority in every state: IDLE next cycle, op_valid=0, no done, err and issued unchanged.
REQ-029 issued SHALL saturate at 2^OP_W.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, opcode=0, op_valid=0, busy=0, done=0, err=0, issued=0 and clear all internal counters.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait for a new start.

Structure
REQ-032 Package op_seq_pkg SHALL hold the state enum, OP_W default and opcode constants OP_000..OP_111.
REQ-033 One sub-module, seq_timer (load/enable/expire down-counter), SHALL serve both the HOLD and TIMEOUT counts.

Verification
REQ-034 start, first=0, last=7, ack 1 cycle after each op_valid -> opcodes 0..7 in order, each held 2 cycles post-ack, issued=8, single done pulse.
REQ-035 first=6, last=1 -> opcodes 6,7,0,1; issued=4; done once.
REQ-036 ack never asserted on opcode 3 -> err=1 after 15 cycles, back to IDLE, no done; next start clears err.
REQ-037 abort during HOLD of opcode 2 -> IDLE next cycle, op_valid=0, issued=3 (from first=0), no done.
REQ-038 rst=0 mid-ISSUE between clock edges -> outputs 0 immediately; start while busy and ack while op_valid=0 -> no effect.
